// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: packs RATIO upstream beats of IN_DW bits into one OUT_DW
// word and writes it into the write side of an async FIFO.
// Lane k of a word is data_o[k*IN_DW +: IN_DW]; the first beat lands in lane 0.
// keep_o marks which lanes of data_o carry real beats (partial words via
// last_i or flush_i).
// Optional build macro FIFO_WR_PACKER_CNT_EN adds word_cnt_o, a saturating
// count of push_o cycles.
//
// Handshake: a beat transfers in any cycle where valid_i && ready_o.
// ready_o depends only on the output register and full_i, never on valid_i.
// A word leaves in any cycle where push_o is high; push_o is never high
// while full_i is high, and data_o/keep_o hold still until the word leaves.
module fifo_wr_packer #(
  parameter int IN_DW = 8,
  parameter int RATIO = 4
) (
  input  logic                   wr_clk_i,
  input  logic                   wr_rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [IN_DW-1:0]       data_i,
  input  logic                   last_i,
  input  logic                   flush_i,
  output logic                   push_o,
  output logic [IN_DW*RATIO-1:0] data_o,
  output logic [RATIO-1:0]       keep_o,
  input  logic                   full_i
`ifdef FIFO_WR_PACKER_CNT_EN
  ,
  output logic [15:0]            word_cnt_o
`endif
);

  localparam int OUT_DW = IN_DW * RATIO;
  localparam int LW     = $clog2(RATIO);
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  logic [OUT_DW-1:0] r_acc_q;
  logic [LW-1:0]     r_cnt_q;
  logic [OUT_DW-1:0] r_out_q;
  logic [RATIO-1:0]  r_keep_q;
  logic              r_out_vld_q;

  logic              w_accept;
  logic              w_close;
  logic              w_flush;
  logic              w_load;
  logic [OUT_DW-1:0] w_merged;
  logic [RATIO-1:0]  w_keep_close;
  logic [RATIO-1:0]  w_keep_flush;

  // The output slot is free when empty or when its word leaves this cycle.
  assign push_o   = r_out_vld_q && !full_i;
  assign ready_o  = !r_out_vld_q || !full_i;
  assign data_o   = r_out_q;
  assign keep_o   = r_keep_q;

  assign w_accept = valid_i && ready_o;
  // A flush that coincides with an accepted beat closes the word on that beat.
  assign w_close  = w_accept && ((r_cnt_q == LAST_LANE) || last_i || flush_i);
  // A flush is acted on only when lanes are pending and the slot is free;
  // otherwise it is dropped, not remembered.
  assign w_flush  = flush_i && (r_cnt_q != '0) && !w_accept &&
                    (!r_out_vld_q || push_o);
  assign w_load   = w_close || w_flush;

  // Accumulator with the incoming beat merged into lane cnt, plus lane masks.
  always_comb begin
    w_merged     = r_acc_q;
    w_keep_close = '0;
    w_keep_flush = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k == int'(r_cnt_q)) begin
        w_merged[k*IN_DW +: IN_DW] = data_i;
      end
      w_keep_close[k] = (k <= int'(r_cnt_q));
      w_keep_flush[k] = (k < int'(r_cnt_q));
    end
  end

  // Accumulator and lane counter; both clear whenever a word is handed off,
  // so lanes above the counter are always zero.
  always_ff @(posedge wr_clk_i or negedge wr_rst_ni) begin
    if (!wr_rst_ni) begin
      r_acc_q <= '0;
      r_cnt_q <= '0;
    end else if (w_load) begin
      r_acc_q <= '0;
      r_cnt_q <= '0;
    end else if (w_accept) begin
      r_acc_q <= w_merged;
      r_cnt_q <= r_cnt_q + LW'(1);
    end
  end

  // Output register: loads a finished word, holds it while the FIFO is full,
  // and stays valid across a push when the next word loads the same cycle.
  always_ff @(posedge wr_clk_i or negedge wr_rst_ni) begin
    if (!wr_rst_ni) begin
      r_out_q     <= '0;
      r_keep_q    <= '0;
      r_out_vld_q <= 1'b0;
    end else if (w_load) begin
      r_out_q     <= w_close ? w_merged : r_acc_q;
      r_keep_q    <= w_close ? w_keep_close : w_keep_flush;
      r_out_vld_q <= 1'b1;
    end else if (push_o) begin
      r_out_vld_q <= 1'b0;
    end
  end

`ifdef FIFO_WR_PACKER_CNT_EN
  logic [15:0] r_word_cnt_q;

  // Saturating count of words written into the FIFO.
  always_ff @(posedge wr_clk_i or negedge wr_rst_ni) begin
    if (!wr_rst_ni) begin
      r_word_cnt_q <= '0;
    end else if (push_o && (r_word_cnt_q != 16'hFFFF)) begin
      r_word_cnt_q <= r_word_cnt_q + 16'd1;
    end
  end

  assign word_cnt_o = r_word_cnt_q;
`endif

endmodule

// File: doc/fifo_wr_packer.md
FIFO_WR_PACKER -- requirements
Module: fifo_wr_packer

Interface
REQ-001 Parameter IN_DW, default 8, upstream beat width in bits (>=1).
REQ-002 Parameter RATIO, default 4, beats per output word (>=2).
REQ-003 Derived localparam OUT_DW = IN_DW*RATIO; LW = $clog2(RATIO); neither overridable.
REQ-004 wr_clk_i  input  1  write-domain clock; all logic on its rising edge.
REQ-005 wr_rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 valid_i  input  1  upstream beat valid.
REQ-007 ready_o  output  1  upstream beat ready.
REQ-008 data_i  input  IN_DW  upstream beat data.
REQ-009 last_i  input  1  beat closes the current word (partial allowed).
REQ-010 flush_i  input  1  single-cycle request to emit a pending partial word.
REQ-011 push_o  output  1  write strobe into async FIFO write side.
REQ-012 data_o  output  OUT_DW  packed word to FIFO.
REQ-013 keep_o  output  RATIO  lane-valid mask of data_o; bit k covers lane k.
REQ-014 full_i  input  1  FIFO full flag, write domain.

Function
REQ-015 Beat accepted iff valid_i && ready_o in a cycle.
REQ-016 Lane k occupies data_o[k*IN_DW +: IN_DW]; first beat of a word goes to lane 0, ascending.
REQ-017 Internal: accumulator acc_q (OUT_DW), lane counter cnt_q (LW bits, 0..RATIO-1), output register out_q/keep_q with out_vld_q.
REQ-018 push_o = out_vld_q && !full_i; data_o = out_q, keep_o = keep_q, held stable while out_vld_q && full_i.
REQ-019 ready_o = !out_vld_q || !full_i (combinational, no dependency on valid_i).
REQ-020 Accepted beat with cnt_q < RATIO-1 and last_i=0: write lane cnt_q of acc_q, cnt_q increments.
REQ-021 Accepted beat with cnt_q == RATIO-1 or last_i=1: next cycle out_q = acc_q merged with this beat, unwritten lanes 0, keep_q = (1<<(cnt_q+1))-1, out_vld_q=1; acc_q and cnt_q clear.
REQ-022 flush_i with cnt_q > 0, no accepted beat, and (!out_vld_q || push_o): emit acc_q as partial word per REQ-021 with keep_q = (1<<cnt_q)-1.
REQ-023 flush_i with cnt_q == 0: no effect; flush_i while output blocked: ignored (not remembered).
REQ-024 flush_i coincident with accepted beat: beat treated as last_i=1.
REQ-025 out_vld_q clears on push_o unless a new word loads the same cycle (back-to-back permitted, no bubble).
REQ-026 Latency: completing beat at cycle N -> push_o earliest at N+1; sustained throughput one beat per cycle.
REQ-027 No word dropped or duplicated; push_o never asserted while full_i=1.

Reset
REQ-028 On wr_rst_ni low: acc_q=0, cnt_q=0, out_q=0, keep_q=0, out_vld_q=0 immediately, asynchronously.
REQ-029 During/after reset: push_o=0, data_o=0, keep_o=0, ready_o=1; reset mid-word discards partial data.

Configuration
REQ-030 Macro FIFO_WR_PACKER_CNT_EN defined: extra output word_cnt_o [15:0], counts push_o cycles, reset 0, saturates at 16'hFFFF.
REQ-031 Macro undefined: word_cnt_o port and counter absent; all other behaviour identical.

Verification
REQ-032 Reset, full_i=0, 4 beats 0x11,0x22,0x33,0x44 consecutive -> one cycle after 4th beat push_o=1, data_o=0x44332211, keep_o=4'hF.
REQ-033 Beats 0xAA,0xBB with last_i on 2nd -> push_o next cycle, data_o=0x0000BBAA, keep_o=4'h3, cnt_q back to 0.
REQ-034 Word pending, full_i=1 for 5 cycles, valid_i held -> ready_o=0, push_o=0, data_o stable; full_i drops -> push_o same cycle, ready_o=1.
REQ-035 Single beat 0x5A then flush_i pulse with idle input -> push_o next cycle, data_o=0x0000005A, keep_o=4'h1; flush_i with cnt_q=0 -> no push.
REQ-036 Reset asserted after 3 beats -> outputs per REQ-029; subsequent 4 beats 0x01..0x04 -> data_o=0x04030201, no residue; with FIFO_WR_PACKER_CNT_EN, word_cnt_o=1.
